// File: rtl/regfile_sb.sv
// regfile_sb: 2**WAD x WD register file with two combinational read ports, one
// writeback port, a per-register pending (busy) scoreboard, an event trigger that
// loads 1 into EVT_REG, and a clear sweep FSM that zeroes registers 1..2**WAD-1.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback and
// trigger data (and the matching busy clear) to the read ports.
module regfile_sb #(
  parameter int unsigned WAD     = 5,
  parameter int unsigned WD      = 32,
  parameter int unsigned EVT_REG = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           regwriteW,
  input  logic [WAD-1:0] rdW,
  input  logic [WD-1:0]  resultW,
  input  logic [WAD-1:0] adin1D,
  input  logic [WAD-1:0] adin2D,
  output logic [WD-1:0]  RD1D,
  output logic [WD-1:0]  RD2D,
  input  logic           issue_en,
  input  logic [WAD-1:0] issue_rd,
  output logic           busy1D,
  output logic           busy2D,
  input  logic           trigger,
  input  logic           clear_req,
  output logic           clear_busy,
  output logic [WD-1:0]  a0
);

  localparam int unsigned NumRegs = 2 ** WAD;
  localparam int unsigned A0Idx   = 10;
  localparam logic [WAD-1:0] EvtAddr = WAD'(EVT_REG);

  typedef enum logic {StIdle, StClear} state_e;

  state_e         state_q;
  logic [WAD-1:0] idx_q;
  logic           clear_busy_q;

  logic [WD-1:0]      regs_q [NumRegs];
  logic [WD-1:0]      regs_d [NumRegs];
  logic [NumRegs-1:0] busy_q, busy_d;

  logic wr_en, trig_en, set_en;

  // All external updates are ignored while the sweep runs.
  assign wr_en   = regwriteW && (rdW != '0) && !clear_busy_q;
  assign trig_en = trigger && !clear_busy_q;
  assign set_en  = issue_en && (issue_rd != '0) && !clear_busy_q;

  // Next-state for array and scoreboard; later assignments take priority.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[rdW] = resultW;
      busy_d[rdW] = 1'b0;
    end
    if (trig_en) regs_d[EvtAddr] = WD'(1);
    if (set_en) busy_d[issue_rd] = 1'b1;
    if (clear_busy_q) begin
      regs_d[idx_q] = '0;
      busy_d[idx_q] = 1'b0;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Register array and busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Clear sweep FSM: walks idx from 1 to 2**WAD-1, one register per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clear_req) begin
            state_q      <= StClear;
            idx_q        <= WAD'(1);
            clear_busy_q <= 1'b1;
          end
        end
        StClear: begin
          if (idx_q == '1) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            clear_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + WAD'(1);
          end
        end
        default: begin
          state_q      <= StIdle;
          idx_q        <= '0;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Read ports, optionally forwarding the same-cycle writeback.
  always_comb begin
    RD1D   = regs_q[adin1D];
    RD2D   = regs_q[adin2D];
    busy1D = busy_q[adin1D];
    busy2D = busy_q[adin2D];
`ifdef REGFILE_BYPASS_EN
    // rst_n gates forwarding so reset forces all read outputs to 0.
    if (rst_n && (adin1D != '0)) begin
      if (wr_en && (adin1D == rdW)) begin
        RD1D   = resultW;
        busy1D = set_en && (issue_rd == adin1D);
      end
      if (trig_en && (adin1D == EvtAddr)) RD1D = WD'(1);
    end
    if (rst_n && (adin2D != '0)) begin
      if (wr_en && (adin2D == rdW)) begin
        RD2D   = resultW;
        busy2D = set_en && (issue_rd == adin2D);
      end
      if (trig_en && (adin2D == EvtAddr)) RD2D = WD'(1);
    end
`endif
  end

  assign a0         = regs_q[A0Idx];
  assign clear_busy = clear_busy_q;

endmodule
